// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline registers:
// occupancy state encoding and the default bubble instruction.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
// Cleared only by the synchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake and a one-entry skid
// buffer so in_ready comes straight from a flop; supports flush and stall counting.
module if_id_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEFAULT_NOP_INST),
    parameter int                CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_PCplus4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] PCplus4,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q,     state_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [ADDR_W-1:0] main_pc_q,   main_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_pc_q,   skid_pc_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;

    logic accept;
    logic consume;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_pc_d   = main_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        if (flush) begin
            // Flush wins: the offered entry (if any) is accepted and dropped.
            state_d     = ST_EMPTY;
            main_inst_d = NOP_INST;
            main_pc_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_inst_d = in_inst;
                        main_pc_d   = in_PCplus4;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_inst_d = in_inst;
                        main_pc_d   = in_PCplus4;
                    end else if (accept) begin
                        state_d     = ST_TWO;
                        skid_inst_d = in_inst;
                        skid_pc_d   = in_PCplus4;
                    end else if (consume) begin
                        state_d     = ST_EMPTY;
                        main_inst_d = NOP_INST;
                        main_pc_d   = '0;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        state_d     = ST_ONE;
                        main_inst_d = skid_inst_q;
                        main_pc_d   = skid_pc_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_inst_d = NOP_INST;
                    main_pc_d   = '0;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= ST_EMPTY;
            main_inst_q <= NOP_INST;
            main_pc_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_pc_q   <= main_pc_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Skid contents are only meaningful in ST_TWO, so they need no reset.
    always_ff @(posedge CLK) begin
        skid_inst_q <= skid_inst_d;
        skid_pc_q   <= skid_pc_d;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK  (CLK),
        .RSTn (RSTn),
        .inc  (out_valid_q & ~out_ready),
        .cnt  (stall_cnt)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign inst      = main_inst_q;
    assign PCplus4   = main_pc_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios then random traffic,
// all compared against a two-deep FIFO reference model.
module tb_if_id_pipe_reg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [ADDR_W-1:0] in_PCplus4;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] PCplus4;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 CLK = ~CLK;

    if_id_pipe_reg #(
        .INST_W   (INST_W),
        .ADDR_W   (ADDR_W),
        .NOP_INST (32'h0),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_PCplus4 (in_PCplus4),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .inst       (inst),
        .PCplus4    (PCplus4),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    ent_t mq[$];
    int   m_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: drive inputs, advance model across the edge, compare after the edge.
    task automatic cycle(input logic rstn, input logic vi, input logic [31:0] ii,
                         input logic [31:0] pp, input logic fl, input logic ordy);
        bit   acc;
        bit   con;
        bit   stl;
        ent_t e;
        RSTn       = rstn;
        in_valid   = vi;
        in_inst    = ii;
        in_PCplus4 = pp;
        flush      = fl;
        out_ready  = ordy;
        acc = vi && (mq.size() < 2);
        con = (mq.size() > 0) && ordy;
        stl = (mq.size() > 0) && !ordy;
        @(posedge CLK);
        cyc++;
        if (!rstn) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if (stl && m_cnt < CNT_MAX) m_cnt++;
            if (fl) mq.delete();
            else begin
                if (con) void'(mq.pop_front());
                if (acc) begin
                    e.inst = ii;
                    e.pc   = pp;
                    mq.push_back(e);
                end
            end
        end
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check_eq("in_ready",  64'(in_ready),  64'(mq.size() < 2));
        check_eq("inst",      64'(inst),      (mq.size() > 0) ? 64'(mq[0].inst) : 64'h0);
        check_eq("PCplus4",   64'(PCplus4),   (mq.size() > 0) ? 64'(mq[0].pc) : 64'h0);
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        $display("cyc %0d rstn=%0b iv=%0b ii=%h fl=%0b or=%0b | ov=%0b ir=%0b inst=%h pc=%h sc=%0d",
                 cyc, rstn, vi, ii, fl, ordy, out_valid, in_ready, inst, PCplus4, stall_cnt);
    endtask

    initial begin
        RSTn = 1'b0; in_valid = 1'b0; in_inst = '0; in_PCplus4 = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset with a pending offer
        cycle(0, 1, 32'hDEADBEEF, 32'h100, 0, 0);
        cycle(0, 1, 32'hDEADBEEF, 32'h100, 0, 0);
        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_inst",      64'(inst),      64'h0);
        check_eq("rst_in_ready",  64'(in_ready),  64'h1);
        check_eq("rst_stall_cnt", 64'(stall_cnt), 64'h0);

        // Streaming
        cycle(1, 1, 32'h11111111, 32'd4, 0, 1);
        check_eq("stream_a", 64'(inst), 64'h11111111);
        cycle(1, 1, 32'h22222222, 32'd8, 0, 1);
        check_eq("stream_b", 64'(inst), 64'h22222222);
        check_eq("stream_pc", 64'(PCplus4), 64'd8);
        cycle(1, 0, 32'h0, 32'h0, 0, 1);

        // Backpressure into the skid
        cycle(1, 1, 32'hA, 32'h10, 0, 0);
        cycle(1, 1, 32'hB, 32'h14, 0, 0);
        check_eq("skid_full_ready", 64'(in_ready), 64'h0);
        check_eq("skid_head", 64'(inst), 64'hA);
        cycle(1, 1, 32'h99, 32'h18, 0, 0);
        cycle(1, 0, 32'h0, 32'h0, 0, 1);
        check_eq("skid_b_next", 64'(inst), 64'hB);
        cycle(1, 0, 32'h0, 32'h0, 0, 1);
        check_eq("skid_drained", 64'(out_valid), 64'h0);

        // Flush while full with an offer pending
        cycle(1, 1, 32'hA, 32'h10, 0, 0);
        cycle(1, 1, 32'hB, 32'h14, 0, 0);
        cycle(1, 1, 32'hE, 32'h1C, 1, 0);
        check_eq("flush2_inst", 64'(inst), 64'h0);
        check_eq("flush2_ready", 64'(in_ready), 64'h1);
        cycle(1, 1, 32'hF, 32'h20, 0, 1);
        check_eq("post_flush", 64'(inst), 64'hF);

        // Flush in ONE with a simultaneous offer
        cycle(1, 1, 32'hC, 32'h24, 1, 0);
        check_eq("flush1_valid", 64'(out_valid), 64'h0);
        cycle(1, 1, 32'hD, 32'h28, 0, 0);
        check_eq("flush1_d", 64'(inst), 64'hD);
        cycle(1, 0, 32'h0, 32'h0, 0, 1);
        check_eq("flush1_alone", 64'(out_valid), 64'h0);

        // Saturation
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        cycle(1, 1, 32'h55, 32'h30, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 32'h0, 32'h0, 0, 0);
        check_eq("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        cycle(1, 0, 32'h0, 32'h0, 0, 1);
        check_eq("sat_hold", 64'(stall_cnt), 64'(CNT_MAX));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  $urandom_range(0, 1),
                  $urandom, $urandom,
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised, handshaked successor to the plain IF/ID latch. It carries instruction and PC+4 from fetch to decode using valid/ready flow control. A one-entry skid buffer lets in_ready be driven from a register, so there is no combinational path from out_ready to in_ready. It also supports flush (bubble insertion) and a saturating stall-cycle counter.

Parameters:
INST_W, 32, instruction width in bits
ADDR_W, 32, PC+4 width in bits
NOP_INST, 0, instruction value presented while the stage holds a bubble
CNT_W, 16, stall counter width

Ports:
CLK  input  1  clock; all state updates on posedge
RSTn  input  1  synchronous, active-low reset
in_valid  input  1  fetch presents an entry
in_ready  output  1  stage accepts an entry this cycle; registered
in_inst  input  INST_W  fetched instruction
in_PCplus4  input  ADDR_W  fetched PC+4
flush  input  1  discard all held entries and the incoming entry
out_valid  output  1  inst/PCplus4 hold a valid entry
out_ready  input  1  decode consumes the entry this cycle
inst  output  INST_W  held instruction; NOP_INST when not valid
PCplus4  output  ADDR_W  held PC+4; 0 when not valid
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturates

Behaviour:
- Clocking and reset: one clock, CLK. Reset RSTn is synchronous and active-low.
- While RSTn=0 at a posedge:
  - state is set to EMPTY;
  - inst=NOP_INST, PCplus4=0, out_valid=0, in_ready=1, stall_cnt=0;
  - skid contents are don't-care.
- Transfer definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- States:
  - EMPTY: 0 entries.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Derived outputs: out_valid = (state != EMPTY); in_ready = (state != TWO). Both are registered with the state.
- Transitions, evaluated when RSTn=1 and flush=0:
  - EMPTY: accept -> ONE, main<=in. Otherwise stay in EMPTY.
  - ONE, accept & consume -> ONE, main<=in.
  - ONE, accept & !consume -> TWO, skid<=in.
  - ONE, !accept & consume -> EMPTY, main<=bubble.
  - ONE, neither -> hold.
  - TWO: consume -> ONE, main<=skid. Otherwise hold. No accept is possible because in_ready=0.
- Bubble: main data is set to inst=NOP_INST, PCplus4=0.
- Latency: an entry accepted in EMPTY, or in ONE with consume, appears on inst/PCplus4 the next cycle.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Flush (RSTn=1, flush=1), priority over all transitions:
  - state <= EMPTY, main <= bubble;
  - an entry offered the same cycle is discarded. If in_ready=1 it counts as accepted-and-dropped;
  - a consume in the same cycle is still a valid consume of the old main entry;
  - stall_cnt is unaffected by flush.
- Stall counter:
  - increments by 1 each cycle with out_valid & !out_ready;
  - holds at 2^CNT_W-1 once reached;
  - cleared only by reset.
- Data stability: while out_valid & !out_ready, inst/PCplus4 do not change.
- Reset mid-operation discards main and skid entries without producing a consume.

Decomposition:
- Shared package (cpu_pipe_pkg): state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2; default NOP_INST constant.
- Sub-module sat_counter (parameter W; inputs CLK, RSTn, inc; output cnt) implements stall_cnt.
- FSM and data registers stay in the top module.

Test Plan:
- Reset: hold RSTn=0 two cycles with in_valid=1, in_inst=32'hDEADBEEF. After the cycle in which RSTn is released: out_valid=0, inst=0, PCplus4=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, feed in_inst=32'h11111111/in_PCplus4=4, then 32'h22222222/8 on consecutive cycles. Outputs follow one cycle later in order; in_ready stays 1.
- Backpressure/skid:
  - Fill with A=32'hA, then B=32'hB while out_ready=0 -> in_ready=0, inst=32'hA, stall_cnt increments each cycle.
  - Raise out_ready -> A consumed, then B.
  - No entry lost or duplicated.
- Flush in TWO with in_valid=1 (in_ready=0): next cycle out_valid=0, inst=NOP_INST, PCplus4=0, in_ready=1. The next accepted entry appears normally.
- Flush in ONE with a simultaneous offer C=32'hC: C dropped, state EMPTY; the following accept of D=32'hD appears alone.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
